lock_supervisor: RTL and testbench

LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

---
 rtl/lock_pkg.sv | 14 +
 rtl/rise_detect.sv | 18 +
 rtl/lock_supervisor.sv | 97 +++++++++
 tb/tb_lock_supervisor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared state encoding and default timing parameters for the lock supervisor.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam int DEF_FAIL_MAX    = 3;
  localparam int DEF_OPEN_CYC    = 8;
  localparam int DEF_LOCKOUT_CYC = 16;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: flags a cycle where d is high but was low at the previous edge.
module rise_detect (
  input  logic CLK,
  input  logic R,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) d_q <= 1'b0;
    else    d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/lock_supervisor.sv
// Supervises the serial lock: releases the door on a good code and locks out
// after FAIL_MAX consecutive wrong codes.
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int FAIL_MAX    = DEF_FAIL_MAX,
  parameter int OPEN_CYC    = DEF_OPEN_CYC,
  parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       Lock,
  input  logic       Alarm,
  output logic       Door,
  output logic       Siren,
  output logic       Blocked,
  output logic [1:0] Fail_cnt
);

  localparam logic [2:0] FAIL_LIMIT   = 3'(FAIL_MAX);
  localparam logic [7:0] OPEN_LOAD    = 8'(OPEN_CYC - 1);
  localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYC - 1);

  state_t     state;
  logic [7:0] timer;
  logic       lock_rise;
  logic       alarm_rise;
  logic [2:0] fail_next;

  rise_detect u_lock_edge (
    .CLK  (CLK),
    .R    (R),
    .d    (Lock),
    .rise (lock_rise)
  );

  rise_detect u_alarm_edge (
    .CLK  (CLK),
    .R    (R),
    .d    (Alarm),
    .rise (alarm_rise)
  );

  assign fail_next = {1'b0, Fail_cnt} + 3'd1;

  // Alarm is checked first so a simultaneous Lock rise is discarded.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state    <= ST_IDLE;
      timer    <= 8'd0;
      Fail_cnt <= 2'd0;
      Door     <= 1'b0;
      Siren    <= 1'b0;
      Blocked  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alarm_rise) begin
            if (fail_next >= FAIL_LIMIT) begin
              state    <= ST_LOCKOUT;
              timer    <= LOCKOUT_LOAD;
              Fail_cnt <= 2'd0;
              Siren    <= 1'b1;
              Blocked  <= 1'b1;
            end else begin
              Fail_cnt <= fail_next[1:0];
            end
          end else if (lock_rise) begin
            state    <= ST_OPEN;
            timer    <= OPEN_LOAD;
            Fail_cnt <= 2'd0;
            Door     <= 1'b1;
            Blocked  <= 1'b1;
          end
        end
        ST_OPEN, ST_LOCKOUT: begin
          if (timer == 8'd0) begin
            state   <= ST_IDLE;
            Door    <= 1'b0;
            Siren   <= 1'b0;
            Blocked <= 1'b0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          timer   <= 8'd0;
          Door    <= 1'b0;
          Siren   <= 1'b0;
          Blocked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor: inputs change and outputs are sampled on the falling edge.
module tb_lock_supervisor;

  logic       CLK;
  logic       R;
  logic       Lock;
  logic       Alarm;
  logic       Door;
  logic       Siren;
  logic       Blocked;
  logic [1:0] Fail_cnt;

  int total = 0;
  int bad   = 0;

  lock_supervisor #(
    .FAIL_MAX    (3),
    .OPEN_CYC    (8),
    .LOCKOUT_CYC (16)
  ) dut (
    .CLK      (CLK),
    .R        (R),
    .Lock     (Lock),
    .Alarm    (Alarm),
    .Door     (Door),
    .Siren    (Siren),
    .Blocked  (Blocked),
    .Fail_cnt (Fail_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic lockV, input logic alarmV);
    Lock  = lockV;
    Alarm = alarmV;
  endtask

  task automatic checkOutput(input string tag, input logic eDoor, input logic eSiren,
                             input logic [1:0] eFail);
    logic eBlocked;
    eBlocked = eDoor | eSiren;
    total++;
    assert (Door === eDoor) else begin
      bad++;
      $error("[TB] FAIL %s Door got=%b exp=%b", tag, Door, eDoor);
    end
    total++;
    assert (Siren === eSiren) else begin
      bad++;
      $error("[TB] FAIL %s Siren got=%b exp=%b", tag, Siren, eSiren);
    end
    total++;
    assert (Blocked === eBlocked) else begin
      bad++;
      $error("[TB] FAIL %s Blocked got=%b exp=%b", tag, Blocked, eBlocked);
    end
    total++;
    assert (Fail_cnt === eFail) else begin
      bad++;
      $error("[TB] FAIL %s Fail_cnt got=%0d exp=%0d", tag, Fail_cnt, eFail);
    end
  endtask

  task automatic waitCheck(input int n, input string tag, input logic eDoor,
                           input logic eSiren, input logic [1:0] eFail);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("%s[%0d]", tag, i), eDoor, eSiren, eFail);
    end
  endtask

  initial begin
    R = 1'b0;
    applyStimulus(1'b0, 1'b0);
    waitCheck(2, "reset", 1'b0, 1'b0, 2'd0);
    R = 1'b1;
    waitCheck(1, "idle0", 1'b0, 1'b0, 2'd0);

    $display("[TB] lock pulse of two cycles");
    applyStimulus(1'b1, 1'b0);
    waitCheck(2, "s1_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(6, "s1_open", 1'b1, 1'b0, 2'd0);
    waitCheck(2, "s1_idle", 1'b0, 1'b0, 2'd0);

    $display("[TB] three alarms into lockout");
    applyStimulus(1'b0, 1'b1);
    waitCheck(2, "s2_f1", 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0);
    waitCheck(1, "s2_f1", 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b1);
    waitCheck(2, "s2_f2", 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0);
    waitCheck(1, "s2_f2", 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b1);
    waitCheck(1, "s2_lock", 1'b0, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(15, "s2_lock", 1'b0, 1'b1, 2'd0);
    waitCheck(1, "s2_idle", 1'b0, 1'b0, 2'd0);

    $display("[TB] two alarms then a good code");
    applyStimulus(1'b0, 1'b1);
    waitCheck(1, "s3_f1", 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0);
    waitCheck(1, "s3_f1", 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b1);
    waitCheck(1, "s3_f2", 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0);
    waitCheck(1, "s3_f2", 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b1, 1'b0);
    waitCheck(1, "s3_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(7, "s3_open", 1'b1, 1'b0, 2'd0);
    waitCheck(1, "s3_idle", 1'b0, 1'b0, 2'd0);

    $display("[TB] simultaneous lock and alarm");
    applyStimulus(1'b1, 1'b1);
    waitCheck(1, "s4_both", 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0);
    waitCheck(2, "s4_idle", 1'b0, 1'b0, 2'd1);

    $display("[TB] alarms ignored while open");
    applyStimulus(1'b1, 1'b0);
    waitCheck(1, "s5_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(1, "s5_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1);
    waitCheck(1, "s5_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(1, "s5_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1);
    waitCheck(1, "s5_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(3, "s5_open", 1'b1, 1'b0, 2'd0);
    waitCheck(1, "s5_idle", 1'b0, 1'b0, 2'd0);

    $display("[TB] lock ignored during lockout, held across exit");
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(1'b0, 1'b1);
      waitCheck(1, "s5_fail", 1'b0, 1'b0, 2'(k));
      applyStimulus(1'b0, 1'b0);
      waitCheck(1, "s5_fail", 1'b0, 1'b0, 2'(k));
    end
    applyStimulus(1'b0, 1'b1);
    waitCheck(1, "s5_lock", 1'b0, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(2, "s5_lock", 1'b0, 1'b1, 2'd0);
    applyStimulus(1'b1, 1'b0);
    waitCheck(13, "s5_lock", 1'b0, 1'b1, 2'd0);
    waitCheck(2, "s5_held", 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(1, "s5_idle", 1'b0, 1'b0, 2'd0);

    $display("[TB] reset during lockout");
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(1'b0, 1'b1);
      waitCheck(1, "s6_fail", 1'b0, 1'b0, 2'(k));
      applyStimulus(1'b0, 1'b0);
      waitCheck(1, "s6_fail", 1'b0, 1'b0, 2'(k));
    end
    applyStimulus(1'b0, 1'b1);
    waitCheck(1, "s6_lock", 1'b0, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(3, "s6_lock", 1'b0, 1'b1, 2'd0);
    R = 1'b0;
    #1;
    checkOutput("s6_async", 1'b0, 1'b0, 2'd0);
    waitCheck(3, "s6_inrst", 1'b0, 1'b0, 2'd0);
    R = 1'b1;
    waitCheck(2, "s6_idle", 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0);
    waitCheck(1, "s6_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(7, "s6_open", 1'b1, 1'b0, 2'd0);
    waitCheck(1, "s6_done", 1'b0, 1'b0, 2'd0);

    $display("[TB] lock already high at reset release");
    R = 1'b0;
    applyStimulus(1'b1, 1'b0);
    waitCheck(1, "s7_inrst", 1'b0, 1'b0, 2'd0);
    R = 1'b1;
    waitCheck(1, "s7_open", 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    waitCheck(7, "s7_open", 1'b1, 1'b0, 2'd0);
    waitCheck(1, "s7_idle", 1'b0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
